axi_wr_tlp: RTL
===============

Name: axi_wr_tlp

Overview:
- AXI4 write slave that converts incoming write bursts into posted Memory Write (MWr) request TLPs.
- It is the outbound counterpart to the inbound TLP-to-AXI master path: local AXI masters write into PCIe space through it.
- Bursts are split into TLPs at max-payload boundaries.
- A B response is returned once the last TLP of the burst has been handed off.

Parameters:
- DOUBLE_WORD, 32, DW width in bits.
- HEADER_SIZE, 4*DOUBLE_WORD, TLP header sideband width.
- TLP_DATA_WIDTH, 8*DOUBLE_WORD, TLP data bus width (one beat = 8 DW = 32 B).
- TLP_STRB_WIDTH, TLP_DATA_WIDTH/8, TLP byte strobes.
- AXI_DATA_WIDTH, TLP_DATA_WIDTH, AXI data width (must equal TLP_DATA_WIDTH).
- AXI_ADDR_WIDTH, 64, AXI address width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, AXI strobe width.
- AXI_ID_WIDTH, 8, AXI ID width.
- MAX_PAYLOAD_BYTES, 256, TLP payload limit; power of two, 32..4096.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- axi_awid  in  AXI_ID_WIDTH  write ID
- axi_awaddr  in  AXI_ADDR_WIDTH  burst start byte address
- axi_awlen  in  8  beats-1
- axi_awsize  in  3  beat size
- axi_awburst  in  2  burst type
- axi_awvalid  in  1  AW valid
- axi_awready  out  1  AW ready
- axi_wdata  in  AXI_DATA_WIDTH  write data
- axi_wstrb  in  AXI_STRB_WIDTH  write strobes
- axi_wlast  in  1  last beat
- axi_wvalid  in  1  W valid
- axi_wready  out  1  W ready
- axi_bid  out  AXI_ID_WIDTH  response ID
- axi_bresp  out  2  response
- axi_bvalid  out  1  B valid
- axi_bready  in  1  B ready
- tlp_data  out  TLP_DATA_WIDTH  payload beat
- tlp_hdr  out  HEADER_SIZE  header, valid with tlp_sop
- tlp_strb  out  TLP_STRB_WIDTH  byte enables
- tlp_sop  out  1  first beat of TLP
- tlp_eop  out  1  last beat of TLP
- tlp_valid  out  1  beat valid
- tlp_ready  in  1  downstream ready
- requester_id  in  16  bus/dev/fn placed in header DW1
- tlp_error  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: state IDLE. axi_awready, axi_wready, axi_bvalid, tlp_valid, tlp_sop, tlp_eop and tlp_error are 0. axi_bid, axi_bresp, tlp_hdr and address/count registers are 0.
- IDLE:
  - axi_awready=1; on the AW handshake, latch id, addr, beats=awlen+1.
  - Legal burst: awburst=INCR, awsize=log2(AXI_STRB_WIDTH), awaddr[4:0]=0. Legal goes to DATA; illegal goes to DROP with bresp latched to SLVERR and tlp_error pulsed.
- DATA: zero-latency pass-through.
  - tlp_valid=axi_wvalid, axi_wready=tlp_ready, tlp_data=wdata, tlp_strb=wstrb.
  - chunk_beats = min(remaining beats, beats to next MAX_PAYLOAD_BYTES address boundary). Because of the alignment rule, a chunk never crosses 4 KB.
  - tlp_sop is high on the first beat of each chunk; tlp_eop is high on the last beat of each chunk.
  - After each eop handshake: addr += chunk_beats*32, remaining -= chunk_beats.
  - When remaining reaches 0, go to RESP with bresp=OKAY.
- Header layout (hdr[31:0]=DW0 ... hdr[127:96]=DW3):
  - DW0: fmt=3'b011 (4DW) if addr[63:32]!=0, else 3'b010 (3DW); type=5'b00000; TC/attr/TD/EP=0; length[9:0]=chunk_beats*8, with 1024 encoded as 0.
  - DW1: requester_id, tag=0, last_be=4'hF, first_be=4'hF. Sub-DW enables are carried only on tlp_strb.
  - 3DW: DW2=addr[31:0], DW3=0. 4DW: DW2=addr[63:32], DW3=addr[31:0].
- wlast checking:
  - If wlast=1 before the counted final beat, or wlast=0 on the counted final beat, pulse tlp_error.
  - Beat framing always follows the AW count, never wlast.
- DROP: axi_wready=1, no TLP output; discard beats until the counted final beat, then go to RESP.
- RESP:
  - axi_bvalid=1 with axi_bid=latched id; hold until axi_bready, then return to IDLE.
  - axi_awready stays 0 outside IDLE (one outstanding burst).
- tlp_hdr is held stable from sop to eop. tlp_valid never drops mid-TLP unless axi_wvalid drops; downstream must tolerate gaps.
- Asynchronous reset mid-burst: a partial TLP is abandoned, no B response is issued, and all outputs return to reset values immediately.

Decomposition:
- Shared package pcie_axi_pkg holds:
  - fmt/type constants (FMT_3DW_D=3'b010, FMT_4DW_D=3'b011, TYPE_MEM=5'b00000);
  - AXI constants (BURST_INCR, RESP_OKAY, RESP_SLVERR);
  - the header DW index constants.
- One sub-module, tlp_hdr_gen: combinational construction of the MWr header from addr, chunk_beats and requester_id. It is reusable by a future read-request path.

Test Plan:
- awaddr=0x1000, awlen=7, MPS=256, tlp_ready=1 -> one 3DW TLP, length=64, DW2=0x1000, 8 beats, sop on beat 0, eop on beat 7; then B with OKAY and bid=awid.
- awaddr=0x1_0000_0F80, awlen=15 -> TLP1 is 4DW with 4 beats (to the 0x...1000 boundary), length=32; TLP2 has 8 beats at 0x...1000; TLP3 has 4 beats at 0x...1100; one B response.
- awburst=FIXED, awlen=3 -> tlp_error pulse, 4 beats accepted with no tlp_valid, bresp=SLVERR.
- tlp_ready toggles every other cycle during an 8-beat burst -> wready mirrors tlp_ready, all 8 beats delivered in order, tlp_hdr stable.
- wlast asserted on beat 2 of awlen=3 -> tlp_error pulse, TLP still ends at beat 3 with eop, bresp=OKAY.
- rst_n asserted after beat 3 of 8 -> tlp_valid and bvalid go 0 immediately; after release, a new AW is accepted in IDLE.

Source files
------------

// File: rtl/pcie_axi_pkg.sv
// Shared constants for the PCIe <-> AXI bridge paths: TLP header encodings,
// AXI burst/response codes, header DW placement and the write-path state type.
package pcie_axi_pkg;

  localparam int DOUBLE_WORD = 32;

  // TLP fmt/type for memory requests carrying data
  localparam logic [2:0] FMT_3DW_D = 3'b010;
  localparam logic [2:0] FMT_4DW_D = 3'b011;
  localparam logic [4:0] TYPE_MEM  = 5'b00000;

  // All byte enables set; partial-DW enables travel on the strobe bus
  localparam logic [3:0] BE_ALL = 4'hF;

  // AXI encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Header DW positions: hdr[31:0] is DW0
  localparam int HDR_DW0 = 0;
  localparam int HDR_DW1 = 1;
  localparam int HDR_DW2 = 2;
  localparam int HDR_DW3 = 3;

  // Bytes carried by one TLP data beat (8 DW)
  localparam int TLP_BEAT_BYTES = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DROP,
    ST_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_wr_tlp_if.sv
// AXI4 write channels (AW/W/B) plus the outbound TLP stream of the write
// bridge. slave = bridge side, master = local AXI master / TLP sink side.
interface axi_wr_tlp_if #(
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int AXI_DATA_WIDTH = TLP_DATA_WIDTH,
  parameter int HEADER_SIZE    = 128
);
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   axi_awid;
  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [7:0]                axi_awlen;
  logic [2:0]                axi_awsize;
  logic [1:0]                axi_awburst;
  logic                      axi_awvalid;
  logic                      axi_awready;

  logic [AXI_DATA_WIDTH-1:0] axi_wdata;
  logic [AXI_STRB_WIDTH-1:0] axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;

  logic [AXI_ID_WIDTH-1:0]   axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  logic [TLP_DATA_WIDTH-1:0] tlp_data;
  logic [HEADER_SIZE-1:0]    tlp_hdr;
  logic [TLP_STRB_WIDTH-1:0] tlp_strb;
  logic                      tlp_sop;
  logic                      tlp_eop;
  logic                      tlp_valid;
  logic                      tlp_ready;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    output tlp_data, tlp_hdr, tlp_strb, tlp_sop, tlp_eop, tlp_valid,
    input  tlp_ready
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    input  tlp_data, tlp_hdr, tlp_strb, tlp_sop, tlp_eop, tlp_valid,
    output tlp_ready
  );

endinterface

// File: rtl/tlp_hdr_gen.sv
// Combinational memory-request header builder. Picks 3DW/4DW from the upper
// address half and encodes the DW length from the beat count (1024 DW -> 0).
module tlp_hdr_gen
  import pcie_axi_pkg::*;
#(
  parameter int HEADER_SIZE = 4*DOUBLE_WORD
) (
  input  logic [63:0]            addr,
  input  logic [7:0]             chunk_beats,
  input  logic [15:0]            requester_id,
  output logic [HEADER_SIZE-1:0] hdr
);

  logic        is_4dw;
  logic [10:0] len_dw;
  logic [9:0]  len_field;
  logic [31:0] dw0, dw1, dw2, dw3;

  // Assemble the four header DWs
  always_comb begin
    is_4dw    = (addr[63:32] != 32'h0);
    len_dw    = {chunk_beats, 3'b000};
    len_field = len_dw[10] ? 10'd0 : len_dw[9:0];
    dw0       = {(is_4dw ? FMT_4DW_D : FMT_3DW_D), TYPE_MEM, 14'h0, len_field};
    dw1       = {requester_id, 8'h00, BE_ALL, BE_ALL};
    if (is_4dw) begin
      dw2 = addr[63:32];
      dw3 = addr[31:0];
    end else begin
      dw2 = addr[31:0];
      dw3 = 32'h0;
    end
    hdr = '0;
    hdr[HDR_DW0*DOUBLE_WORD +: DOUBLE_WORD] = dw0;
    hdr[HDR_DW1*DOUBLE_WORD +: DOUBLE_WORD] = dw1;
    hdr[HDR_DW2*DOUBLE_WORD +: DOUBLE_WORD] = dw2;
    hdr[HDR_DW3*DOUBLE_WORD +: DOUBLE_WORD] = dw3;
  end

endmodule

// File: rtl/axi_wr_tlp.sv
// AXI4 write slave -> posted MWr TLP source. W beats stream straight through
// to the TLP bus; bursts are cut at max-payload address boundaries, and a B
// response follows the final TLP. Framing is driven by AWLEN, not WLAST.
//
// state   | meaning
// IDLE    | waiting for AW, awready high
// DATA    | legal burst, W beats forwarded as TLP beats
// DROP    | illegal burst, W beats swallowed
// RESP    | B response presented until bready
module axi_wr_tlp
  import pcie_axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH      = 8,
  parameter int AXI_STRB_WIDTH    = 32,
  parameter int HEADER_SIZE       = 4*DOUBLE_WORD,
  parameter int MAX_PAYLOAD_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_wr_tlp_if.slave bus,
  input  logic [15:0] requester_id,
  output logic        tlp_error
);

  localparam int         MPS_BEATS   = MAX_PAYLOAD_BYTES / TLP_BEAT_BYTES;
  localparam logic [6:0] MPS_MASK    = 7'(MPS_BEATS - 1);
  localparam logic [2:0] AWSIZE_FULL = 3'($clog2(AXI_STRB_WIDTH));

  wr_state_e               state_q, state_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [63:0]             addr_q, addr_d;
  logic [8:0]              rem_q, rem_d;
  logic [8:0]              beat_q, beat_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    err_q, err_d;

  logic [6:0]             off_beats;
  logic [8:0]             to_bound;
  logic [8:0]             chunk_beats;
  logic                   last_of_chunk;
  logic                   final_beat;
  logic                   aw_legal;
  logic                   w_hs;
  logic [HEADER_SIZE-1:0] hdr_w;

  // Current chunk geometry; addr_q/rem_q only move on eop so this is stable per TLP
  always_comb begin
    off_beats     = addr_q[11:5] & MPS_MASK;
    to_bound      = 9'(MPS_BEATS) - {2'b00, off_beats};
    chunk_beats   = (rem_q < to_bound) ? rem_q : to_bound;
    last_of_chunk = (beat_q == (chunk_beats - 9'd1));
    final_beat    = last_of_chunk && (rem_q == chunk_beats);
    aw_legal      = (bus.axi_awburst == BURST_INCR) &&
                    (bus.axi_awsize == AWSIZE_FULL) &&
                    (bus.axi_awaddr[4:0] == 5'd0);
    w_hs          = bus.axi_wvalid && bus.axi_wready;
  end

  tlp_hdr_gen #(
    .HEADER_SIZE (HEADER_SIZE)
  ) u_hdr_gen (
    .addr         (addr_q),
    .chunk_beats  (chunk_beats[7:0]),
    .requester_id (requester_id),
    .hdr          (hdr_w)
  );

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    bresp_d = bresp_q;
    err_d   = 1'b0;

    bus.axi_wready = 1'b0;
    bus.axi_bvalid = 1'b0;
    bus.tlp_valid  = 1'b0;
    bus.tlp_sop    = 1'b0;
    bus.tlp_eop    = 1'b0;
    bus.tlp_data   = '0;
    bus.tlp_strb   = '0;
    bus.tlp_hdr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.axi_awvalid) begin
          id_d   = bus.axi_awid;
          addr_d = bus.axi_awaddr;
          rem_d  = {1'b0, bus.axi_awlen} + 9'd1;
          beat_d = '0;
          if (aw_legal) begin
            state_d = ST_DATA;
            bresp_d = RESP_OKAY;
          end else begin
            state_d = ST_DROP;
            bresp_d = RESP_SLVERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_DATA: begin
        bus.tlp_valid  = bus.axi_wvalid;
        bus.axi_wready = bus.tlp_ready;
        bus.tlp_data   = bus.axi_wdata;
        bus.tlp_strb   = bus.axi_wstrb;
        bus.tlp_hdr    = hdr_w;
        bus.tlp_sop    = bus.axi_wvalid && (beat_q == 9'd0);
        bus.tlp_eop    = bus.axi_wvalid && last_of_chunk;
        if (w_hs) begin
          if (bus.axi_wlast != final_beat) err_d = 1'b1;
          if (last_of_chunk) begin
            addr_d = addr_q + {50'd0, chunk_beats, 5'd0};
            rem_d  = rem_q - chunk_beats;
            beat_d = '0;
            if (final_beat) state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end

      ST_DROP: begin
        bus.axi_wready = 1'b1;
        if (bus.axi_wvalid) begin
          if (bus.axi_wlast != (rem_q == 9'd1)) err_d = 1'b1;
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1) state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        bus.axi_bvalid = 1'b1;
        if (bus.axi_bready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // awready is qualified by reset so it reads low while reset is held
  assign bus.axi_awready = (state_q == ST_IDLE) && rst_n;
  assign bus.axi_bid     = id_q;
  assign bus.axi_bresp   = bresp_q;
  assign tlp_error       = err_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      bresp_q <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      bresp_q <= bresp_d;
      err_q   <= err_d;
    end
  end

endmodule
